// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras -- program counter with an integrated return-address stack (RAS)
//
// Holds the fetch address for the multi-cycle MIPS datapath. Under a 2-bit
// select the PC is loaded, loaded with a push of the return address (call),
// incremented, or loaded from the top of the stack (return).
//
// Optional feature macro:
//   PC_RAS_WRAP_EN  defined   : a call on a full stack overwrites the oldest
//                               entry (circular). The count stays at DEPTH and
//                               no error is raised.
//                   undefined : a call on a full stack still loads the PC,
//                               but the push is dropped and ras_err is set.
//
// Parameters:
//   WIDTH      PC / address width in bits
//   DEPTH      number of stack entries (power of two, >= 2)
//   INC        increment for sequential fetch and return addresses
//   RESET_VEC  PC value after reset
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   update enable; 0 holds all state
//   sr         in   operation: 0 load, 1 call, 2 increment, 3 return
//   address    in   target for load/call; fallback PC for return on empty
//   pcout      out  registered current PC
//   ras_count  out  number of valid stack entries
//   ras_full   out  ras_count == DEPTH
//   ras_empty  out  ras_count == 0
//   ras_err    out  sticky overflow/underflow flag (cleared only by reset)
//
// Handshake: there is no valid/ready pair. Every rising edge with en=1 is
// one accepted operation; its result is visible on the outputs after that
// edge and stays until the next accepted operation or reset.
// ---------------------------------------------------------------------------
module pc_ras #(
   parameter int unsigned       WIDTH     = 32,
   parameter int unsigned       DEPTH     = 4,
   parameter int unsigned       INC       = 4,
   parameter logic [WIDTH-1:0]  RESET_VEC = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic [1:0]                 sr,
   input  logic [WIDTH-1:0]           address,
   output logic [WIDTH-1:0]           pcout,
   output logic [$clog2(DEPTH+1)-1:0] ras_count,
   output logic                       ras_full,
   output logic                       ras_empty,
   output logic                       ras_err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
   localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      OP_LOAD = 2'd0,
      OP_CALL = 2'd1,
      OP_INC  = 2'd2,
      OP_RET  = 2'd3
   } op_e;

   op_e              op;
   logic [WIDTH-1:0] pc_q,   pc_d;
   logic [CW-1:0]    cnt_q,  cnt_d;
   logic [PW-1:0]    wp_q,   wp_d;
   logic             err_q,  err_d;
   logic [WIDTH-1:0] stack_q [DEPTH];

   logic             push;
   logic [WIDTH-1:0] push_data;
   logic [PW-1:0]    top_idx;
   logic             full;
   logic             empty;

   assign op    = op_e'(sr);
   assign full  = (cnt_q == DEPTH_C);
   assign empty = (cnt_q == '0);

   // wp_q points at the next free slot, so the newest entry sits one below
   // it. DEPTH is a power of two, so the pointer wraps by plain overflow.
   assign top_idx   = wp_q - PW'(1);
   assign push_data = address + INC_W;

   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      wp_d  = wp_q;
      err_d = err_q;
      push  = 1'b0;

      if (en) begin
         unique case (op)
            OP_LOAD: begin
               pc_d = address;
            end
            OP_CALL: begin
               pc_d = address;
               if (!full) begin
                  push  = 1'b1;
                  wp_d  = wp_q + PW'(1);
                  cnt_d = cnt_q + CW'(1);
               end else begin
`ifdef PC_RAS_WRAP_EN
                  // Full: wp_q aliases the oldest slot, so writing there
                  // and advancing drops the oldest entry; count stays DEPTH.
                  push = 1'b1;
                  wp_d = wp_q + PW'(1);
`else
                  err_d = 1'b1;
`endif
               end
            end
            OP_INC: begin
               pc_d = pc_q + INC_W;
            end
            OP_RET: begin
               if (empty) begin
                  pc_d  = address;
                  err_d = 1'b1;
               end else begin
                  pc_d  = stack_q[top_idx];
                  wp_d  = top_idx;
                  cnt_d = cnt_q - CW'(1);
               end
            end
            default: begin
               pc_d = pc_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_VEC;
         cnt_q <= '0;
         wp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         wp_q  <= wp_d;
         err_q <= err_d;
      end
   end

   // Stack storage is not reset: the count alone defines which entries are
   // meaningful, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_q[wp_q] <= push_data;
      end
   end

   assign pcout     = pc_q;
   assign ras_count = cnt_q;
   assign ras_full  = full;
   assign ras_empty = empty;
   assign ras_err   = err_q;

endmodule

// File: doc/pc_ras.md
# pc_ras

Parametrised program counter with an integrated return-address stack (RAS) for the multi-cycle MIPS datapath. It holds the fetch address, and supports load, call (load plus push of the return address), sequential increment and return (pop) under a 2-bit select. It replaces the single-slot store/restore PC with a stack of configurable depth, full/empty status and error reporting. It sits between the control FSM (`sr`, `en`) and instruction-memory address generation.

## Interface
Parameters:
- `WIDTH`, 32, PC and address width in bits.
- `DEPTH`, 4, RAS entries; power of two, ≥2.
- `INC`, 4, increment added for return addresses and sequential fetch.
- `RESET_VEC`, 0, PC value after reset.

Ports:
- `clk`  in  1  clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  update enable; 0 holds all state.
- `sr`  in  2  operation select: 0 load, 1 call, 2 increment, 3 return.
- `address`  in  WIDTH  target address for load/call; fallback for return on empty.
- `pcout`  out  WIDTH  registered current PC.
- `ras_count`  out  $clog2(DEPTH+1)  valid stack entries.
- `ras_full`  out  1  `ras_count == DEPTH`.
- `ras_empty`  out  1  `ras_count == 0`.
- `ras_err`  out  1  sticky overflow/underflow flag.

## Operation
- Reset (async, `rst_n`=0): `pcout`=`RESET_VEC`, `ras_count`=0, `ras_empty`=1, `ras_full`=0, `ras_err`=0. Stack contents are don't-care.
- `en`=0: PC, stack, count and `ras_err` all hold, whatever `sr` is.
- `sr`=0 (load): PC ← `address`; stack unchanged.
- `sr`=1 (call): PC ← `address`; push (`address`+`INC`) mod 2^WIDTH; count +1.
- `sr`=2 (increment): PC ← (PC+`INC`) mod 2^WIDTH; stack unchanged.
- `sr`=3 (return): PC ← top entry; pop; count −1.
- Stack is LIFO. It is implemented as a circular buffer with a write pointer of $clog2(DEPTH) bits; pointers wrap modulo DEPTH.
- Return on empty (underflow):
  - PC ← `address`.
  - Count stays 0.
  - `ras_err` ← 1.
- Call on full: behaviour is set by `PC_RAS_WRAP_EN` (see Configuration).
- All arithmetic wraps modulo 2^WIDTH; no carry out.

## Timing
- All updates occur on the rising `clk` edge where `en`=1. `pcout` reflects the new value one cycle after the inputs are sampled.
- `ras_full`, `ras_empty` and `ras_count` are registered or derived from the registered count, and are valid in the same cycle as `pcout`.
- A return immediately following a call (back-to-back, `en`=1 both cycles) yields `address_call`+`INC`; no bubble is required.
- `ras_err` rises the cycle after the offending operation and stays high until `rst_n` is asserted.
- Reset asserted mid-sequence clears all state immediately, independent of `clk`. The first operation after deassertion sees an empty stack.

## Configuration
- `PC_RAS_WRAP_EN` defined:
  - Call on full overwrites the oldest entry (circular); count stays `DEPTH`; `ras_err` is not set.
  - A following return yields the newest entry.
  - After DEPTH+k calls, only the latest DEPTH return addresses are recoverable.
- `PC_RAS_WRAP_EN` undefined:
  - Call on full still loads PC ← `address`, but the push is dropped.
  - Stack contents and count are unchanged; `ras_err` ← 1.

## Test plan
- Reset then idle: `rst_n`=0 then 1, `en`=0, `sr`=2 for 3 cycles -> `pcout`=0, `ras_empty`=1, `ras_err`=0 throughout.
- Single call/return: call `address`=244 -> `pcout`=244, `ras_count`=1. Two increments -> `pcout`=252. Return -> `pcout`=248, `ras_empty`=1.
- Nested calls (DEPTH=4): calls to 0x100, 0x200, 0x300, 0x400 -> `ras_full`=1. Four returns -> `pcout` = 0x404, 0x304, 0x204, 0x104; then `ras_empty`=1, `ras_err`=0.
- Overflow, 5th call to 0x500 on full:
  - Without the macro: `ras_err`=1, `pcout`=0x500; four returns yield 0x404…0x104.
  - With the macro: `ras_err`=0; four returns yield 0x504, 0x404, 0x304, 0x204.
- Underflow: return on empty with `address`=0x80 -> `pcout`=0x80, `ras_count`=0, `ras_err`=1. A later load leaves `ras_err`=1.
- Async reset mid-stack: after 2 calls, pulse `rst_n` low between clock edges -> `pcout`=`RESET_VEC` and `ras_count`=0 before the next edge. A return afterwards underflows.
